// File: rtl/dc_access_arbiter.sv
// dc_access_arbiter
// Shares the single data-cache access port between the memory-response
// holding register (requester 0, m_d path) and the ring-incoming holding
// register (requester 1, in_d path). One pending flit set is granted by
// round-robin and held on dc_flits until the data cache reports completion.
// The granted source then gets a one-cycle done strobe so it can clear itself.
// A watchdog aborts an access that sees no completion within TIMEOUT busy
// cycles. It strobes done to release the source and sets a sticky error flag.
//
// TIMEOUT must lie in 2..255, and CNT_W must be wide enough to hold TIMEOUT-1.

module dc_access_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [143:0]   m_d_areg_flits,
  input  logic           v_m_d_areg_flits,
  input  logic [143:0]   in_d_areg_flits,
  input  logic           v_in_d_areg_flits,
  input  logic           dc_done_access,
  output logic [143:0]   dc_flits,
  output logic           v_dc_flits,
  output logic           done_m_d,
  output logic           done_in_d,
  output logic           arb_busy,
  output logic           arb_grant,
  output logic           err_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Last counter value before the watchdog fires. The first BUSY cycle
  // sees a count of 0, so the TIMEOUT-th BUSY cycle sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q,     state_d;
  logic [143:0]       dc_flits_q,  dc_flits_d;
  logic               arb_grant_q, arb_grant_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               err_q,       err_d;

  logic               any_req;
  logic               grant_sel;
  logic               timeout_hit;
  logic               release_src;

  // Round-robin pick. When both requesters are pending, the one that did not
  // win last time is chosen. Otherwise the only pending requester is chosen.
  always_comb begin
    any_req   = v_m_d_areg_flits | v_in_d_areg_flits;
    grant_sel = (v_m_d_areg_flits & v_in_d_areg_flits) ? ~arb_grant_q
                                                         : v_in_d_areg_flits;
  end

  // Watchdog expiry. A completion in the same cycle takes priority, so
  // that case does not count as a timeout.
  always_comb begin
    timeout_hit = (state_q == BUSY) && !dc_done_access && (cnt_q == CNT_LAST);
  end

  // State and datapath registers, with synchronous reset to the idle values.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dc_flits_q  <= '0;
      arb_grant_q <= 1'b1;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dc_flits_q  <= dc_flits_d;
      arb_grant_q <= arb_grant_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath update: grant from IDLE, and finish or abort
  // from BUSY.
  always_comb begin
    // NOTE: every signal gets a hold default before the case, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    dc_flits_d  = dc_flits_q;
    arb_grant_d = arb_grant_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = BUSY;
          arb_grant_d = grant_sel;
          dc_flits_d  = grant_sel ? in_d_areg_flits : m_d_areg_flits;
          cnt_d       = '0;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dc_done_access) begin
          state_d    = IDLE;
          dc_flits_d = '0;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          dc_flits_d = '0;
          err_d      = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. The done strobes are combinational, so the granted
  // source clears at the same edge that returns the arbiter to IDLE.
  always_comb begin
    release_src = (state_q == BUSY) & (dc_done_access | timeout_hit);
    arb_busy    = (state_q == BUSY);
    v_dc_flits  = (state_q == BUSY);
    dc_flits    = dc_flits_q;
    arb_grant   = arb_grant_q;
    err_timeout = err_q;
    done_m_d    = release_src & ~arb_grant_q;
    done_in_d   = release_src &  arb_grant_q;
  end

endmodule
